// File: rtl/serial_twos_comp_pkg.sv
// rtl/serial_twos_comp_pkg.sv - shared types and constants for the serial two's-complement link
package serial_twos_comp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } state_e;

  localparam int DEFAULT_WIDTH = 8;

  // Bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits never wrap early.
  function automatic int cnt_width(input int w);
    return (w > 2) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_twos_comp_rx_if.sv
// rtl/serial_twos_comp_rx_if.sv - handshake and data bundle for the serial two's-complement receiver
interface serial_twos_comp_rx_if
  import serial_twos_comp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic             serial_in;
  logic             shift_control;
  logic [WIDTH-1:0] data_out;
  logic             data_valid;
  logic             busy;

  modport master (
    output start, serial_in, shift_control,
    input  data_out, data_valid, busy
  );

  modport slave (
    input  start, serial_in, shift_control,
    output data_out, data_valid, busy
  );

endinterface

// File: rtl/serial_twos_comp_cell.sv
// rtl/serial_twos_comp_cell.sv - flag-and-XOR negation cell, shared by transmitter and receiver
module serial_twos_comp_cell (
  input  logic Clock,
  input  logic reset_b,
  input  logic clr,
  input  logic en,
  input  logic bit_in,
  output logic bit_out
);

  logic q_q;
  logic q_d;

  // Bits pass through until the first 1 has been seen; every later bit is inverted.
  assign bit_out = bit_in ^ q_q;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = 1'b0;
    end else if (en) begin
      q_d = q_q | bit_in;
    end
  end

  always_ff @(posedge Clock or negedge reset_b) begin
    if (!reset_b) begin
      q_q <= 1'b0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/serial_twos_comp_rx.sv
// rtl/serial_twos_comp_rx.sv - LSB-first serial receiver that recovers a two's-complement word
module serial_twos_comp_rx
  import serial_twos_comp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input logic                  Clock,
  input logic                  reset_b,
  serial_twos_comp_rx_if.slave rx
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] sreg_q;
  logic [WIDTH-1:0] sreg_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] data_out_q;
  logic             data_valid_q;
  logic             busy_q;
  logic             cell_clr;
  logic             cell_en;
  logic             y;

  always_comb begin
    cell_clr = rx.start && (state_q == IDLE || state_q == DONE);
    cell_en  = rx.shift_control && (state_q == RECV);
    sreg_d   = {y, sreg_q[WIDTH-1:1]};
  end

  serial_twos_comp_cell u_cell (
    .Clock   (Clock),
    .reset_b (reset_b),
    .clr     (cell_clr),
    .en      (cell_en),
    .bit_in  (rx.serial_in),
    .bit_out (y)
  );

  always_ff @(posedge Clock or negedge reset_b) begin
    if (!reset_b) begin
      state_q      <= IDLE;
      sreg_q       <= '0;
      cnt_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      data_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rx.start) begin
            state_q <= RECV;
            sreg_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        RECV: begin
          if (rx.shift_control) begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BIT) begin
              state_q      <= DONE;
              data_out_q   <= sreg_d;
              data_valid_q <= 1'b1;
              busy_q       <= 1'b0;
            end
          end
        end
        DONE: begin
          // A start here chains the next word with no idle cycle in between.
          if (rx.start) begin
            state_q <= RECV;
            sreg_q  <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign rx.data_out   = data_out_q;
  assign rx.data_valid = data_valid_q;
  assign rx.busy       = busy_q;

endmodule

// File: tb/tb_serial_twos_comp_rx.sv
// tb/tb_serial_twos_comp_rx.sv - directed self-checking bench for serial_twos_comp_rx
module tb_serial_twos_comp_rx;

  logic Clock = 1'b0;
  logic reset_b;
  int   vecs = 0;
  int   errs = 0;
  int   valid_cnt;
  logic busy_ok;
  logic [7:0] w;
  logic [7:0] expv;

  serial_twos_comp_rx_if #(.WIDTH(8)) bus ();

  serial_twos_comp_rx #(.WIDTH(8)) dut (
    .Clock   (Clock),
    .reset_b (reset_b),
    .rx      (bus)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    vecs++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp_v);
    vecs++;
    assert (obs === exp_v) else begin
      errs++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp_v);
    end
  endtask

  task automatic begin_word();
    bus.start = 1'b1;
    bus.shift_control = 1'b0;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic shift_bits(input logic [7:0] x, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      bus.serial_in = x[i];
      bus.shift_control = 1'b1;
      tick();
    end
    bus.shift_control = 1'b0;
  endtask

  task automatic send_word(input logic [7:0] x, input logic [7:0] exp_v, input string tag);
    begin_word();
    shift_bits(x, 8);
    chk1({tag, "_valid"}, bus.data_valid, 1'b1);
    chk8({tag, "_data"}, bus.data_out, exp_v);
    tick();
    chk1({tag, "_valid_drop"}, bus.data_valid, 1'b0);
  endtask

  initial begin
    reset_b = 1'b0;
    bus.start = 1'b0;
    bus.serial_in = 1'b0;
    bus.shift_control = 1'b0;
    tick();
    chk8("rst_data", bus.data_out, 8'h00);
    chk1("rst_valid", bus.data_valid, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    reset_b = 1'b1;
    tick();

    // 0xFB: data_valid must not appear before the 8th bit
    begin_word();
    chk1("fb_busy", bus.busy, 1'b1);
    shift_bits(8'hFB, 7);
    chk1("fb_early_valid", bus.data_valid, 1'b0);
    shift_bits(8'h01, 1);
    chk1("fb_valid", bus.data_valid, 1'b1);
    chk8("fb_data", bus.data_out, 8'h05);
    chk1("fb_busy_done", bus.busy, 1'b0);
    tick();
    chk1("fb_valid_drop", bus.data_valid, 1'b0);
    chk8("fb_hold", bus.data_out, 8'h05);

    send_word(8'h01, 8'hFF, "w01");
    send_word(8'h00, 8'h00, "w00");
    send_word(8'h80, 8'h80, "w80");

    // 0x9C with 0..3 idle gaps and a stray start mid-word
    w = 8'h9C;
    begin_word();
    valid_cnt = 0;
    busy_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      for (int g = 0; g < i % 4; g++) begin
        bus.shift_control = 1'b0;
        bus.serial_in = 1'($urandom_range(0, 1));
        bus.start = (i == 5 && g == 0);
        tick();
        if (!bus.busy) busy_ok = 1'b0;
        if (bus.data_valid) valid_cnt++;
      end
      bus.start = 1'b0;
      bus.serial_in = w[i];
      bus.shift_control = 1'b1;
      tick();
      if (i < 7 && !bus.busy) busy_ok = 1'b0;
      if (bus.data_valid) valid_cnt++;
    end
    bus.shift_control = 1'b0;
    chk1("gap_busy", busy_ok, 1'b1);
    chk8("gap_data", bus.data_out, 8'h64);
    for (int k = 0; k < 3; k++) begin
      tick();
      if (bus.data_valid) valid_cnt++;
    end
    chk8("gap_one_pulse", 8'(valid_cnt), 8'd1);

    // back-to-back words with start in the DONE cycle
    begin_word();
    shift_bits(8'hFB, 8);
    chk1("b2b_valid1", bus.data_valid, 1'b1);
    chk8("b2b_data1", bus.data_out, 8'h05);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk1("b2b_busy", bus.busy, 1'b1);
    chk1("b2b_valid_gap", bus.data_valid, 1'b0);
    shift_bits(8'h02, 8);
    chk1("b2b_valid2", bus.data_valid, 1'b1);
    chk8("b2b_data2", bus.data_out, 8'hFE);
    tick();

    // asynchronous reset mid-word
    begin_word();
    shift_bits(8'hFB, 4);
    bus.shift_control = 1'b1;
    #2;
    reset_b = 1'b0;
    #1;
    chk8("arst_data", bus.data_out, 8'h00);
    chk1("arst_valid", bus.data_valid, 1'b0);
    chk1("arst_busy", bus.busy, 1'b0);
    tick();
    reset_b = 1'b1;
    valid_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.data_valid) valid_cnt++;
    end
    bus.shift_control = 1'b0;
    chk8("arst_no_valid", 8'(valid_cnt), 8'd0);
    send_word(8'h03, 8'hFD, "w03");

    // sweep of every input value against -x mod 256
    for (int x = 0; x < 256; x++) begin
      w = 8'(x);
      expv = 8'(256 - x);
      begin_word();
      shift_bits(w, 8);
      chk8("sweep_data", bus.data_out, expv);
      tick();
      tick();
      chk8("sweep_hold", bus.data_out, expv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/serial_twos_comp_rx.md
Name: serial_twos_comp_rx

Overview:
Serial receiver and two's-complement decoder. It accepts an LSB-first serial bit stream produced by the serial two's-complement transmitter and applies the same flag-and-XOR negation algorithm. Because negation is its own inverse, the original value is recovered. The block deserialises WIDTH bits into a parallel word and pulses data_valid once per completed word. It sits at the receiving end of the serial arithmetic link.

Parameters:
WIDTH, 8, word length in bits; legal range 2..32.

Ports:
Clock  input  1  system clock; all state changes on the rising edge.
reset_b  input  1  asynchronous, active-low reset.
start  input  1  begin a new word; sampled in IDLE and DONE only.
serial_in  input  1  incoming bit, LSB first.
shift_control  input  1  qualifies serial_in; a bit is accepted only when this is 1 and the state is RECV.
data_out  output  WIDTH  last fully received and decoded word; holds until the next completion.
data_valid  output  1  one-cycle pulse when data_out is updated.
busy  output  1  high while in RECV.

Behaviour:
- Reset (asynchronous, reset_b=0):
  - state=IDLE, SReg=0, Q=0, bit count=0.
  - data_out=0, data_valid=0, busy=0.
  - Reset during RECV discards the partial word; no data_valid is produced.
- States: IDLE, RECV, DONE. busy=1 only in RECV. data_valid=1 only in DONE.
- IDLE:
  - start=1 -> RECV. Clear SReg, Q and count.
  - Otherwise stay in IDLE.
- RECV, on each edge with shift_control=1:
  - y = serial_in XOR Q.
  - SReg <= {y, SReg[WIDTH-1:1]}.
  - Q <= Q OR serial_in.
  - count <= count+1.
- RECV, edge with shift_control=0: hold all state, with no limit on gap length.
- start while in RECV is ignored.
- Completion:
  - On the edge that accepts bit WIDTH-1 (count==WIDTH-1), data_out <= {y, SReg[WIDTH-1:1]}.
  - Same edge: state -> DONE.
  - data_valid is high for exactly the following cycle.
  - Latency from the last accepted bit to data_valid is 1 cycle.
- DONE (one cycle only):
  - start=1 -> RECV with SReg, Q and count cleared, giving back-to-back words without an idle cycle.
  - Otherwise -> IDLE.
  - shift_control in DONE is ignored.
- Arithmetic:
  - Output is modulo 2^WIDTH.
  - The most negative value is its own negation: 0x80 -> 0x80 for WIDTH=8.
  - Zero maps to zero, and Q never sets.
- Counter width is clog2(WIDTH). The counter must not wrap before completion.
- Outputs are registered or decoded from state only. There is no combinational path from inputs to outputs.

Decomposition:
- Shared package serial_twos_comp_pkg:
  - state enum {IDLE, RECV, DONE}.
  - DEFAULT_WIDTH=8.
  - Helper constant for the counter width.
- One natural sub-module, serial_twos_comp_cell:
  - Contains the Q flip-flop, the XOR, and the enable and clear inputs.
  - The same cell is reusable by the transmitter.
  - Ports: Clock, reset_b, clr, en, bit_in, bit_out.

Test Plan:
- Reset then start; shift 0xFB LSB-first (1,1,0,1,1,1,1,1), shift_control held at 1 -> data_valid one cycle after the 8th bit; data_out=0x05.
- Shift 0x01 -> data_out=0xFF. Shift 0x00 -> data_out=0x00. Shift 0x80 -> data_out=0x80.
- Shift 0x9C with shift_control gaps of 0-3 cycles between bits, and start pulsed mid-word -> data_out=0x64; exactly one data_valid pulse; busy high throughout.
- Back-to-back: start asserted in the DONE cycle, then a second word 0x02 -> first word 0x05, then data_out=0xFE; no IDLE cycle between the words.
- Assert reset_b=0 after 4 bits of 0xFB -> all outputs 0 immediately (asynchronous), no data_valid; a fresh word 0x03 afterwards -> data_out=0xFD.
- Sweep all 256 inputs against a reference model of (-x mod 256) -> all outputs match; data_out is unchanged between pulses.
